// File: rtl/abr_params_pkg.sv
// Shared memory-interface types and geometry for the ABR memory banks.
// Consumed by abr_mem_responder and its sweep sub-module.
package abr_params_pkg;

    localparam int ABR_MEM_ADDR_WIDTH  = 14;
    localparam int ABR_MEM_DATA_WIDTH  = 96;
    localparam int ABR_MEM_INST0_DEPTH = 832;
    localparam int ABR_MEM_INST1_DEPTH = 576;

    typedef enum logic [1:0] {
        RW_IDLE  = 2'b00,
        RW_READ  = 2'b01,
        RW_WRITE = 2'b10
    } mem_rw_mode_e;

    typedef struct packed {
        mem_rw_mode_e                  rd_wr_en;
        logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
    } mem_if_t;

endpackage

// File: rtl/abr_mem_zeroize_sweep.sv
// Zeroize sweep FSM: walks every row once, ascending, after a zeroize pulse.
// Only instantiated when ABR_MEM_RESPONDER_ZEROIZE_EN is defined.
module abr_mem_zeroize_sweep #(
    parameter int DEPTH = 832,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          zeroize,
    output logic          busy_o,
    output logic [AW-1:0] row_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_e;

    localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

    sweep_state_e  state_r;
    logic [AW-1:0] row_r;

    // State and row counter; zeroize is ignored once the sweep is running.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            row_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    row_r <= '0;
                    if (zeroize) begin
                        state_r <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (row_r == LAST_ROW) begin
                        state_r <= IDLE;
                        row_r   <= '0;
                    end else begin
                        row_r <= row_r + AW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    row_r   <= '0;
                end
            endcase
        end
    end

    assign busy_o = (state_r == SWEEP);
    assign row_o  = row_r;

endmodule

// File: rtl/abr_mem_responder.sv
// Single-bank SRAM responder: decodes bank/row, drives a registered SRAM strobe
// and returns read data in order. Zeroize sweep gated by ABR_MEM_RESPONDER_ZEROIZE_EN.
module abr_mem_responder
    import abr_params_pkg::*;
#(
    parameter int BANK_ID     = 0,
    parameter int DEPTH       = ABR_MEM_INST0_DEPTH,
    parameter int SRAM_RD_LAT = 1,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          zeroize,
    input  mem_if_t                       mem_req_i,
    input  logic [ABR_MEM_DATA_WIDTH-1:0] wdata_i,
    output logic [ABR_MEM_DATA_WIDTH-1:0] rdata_o,
    output logic                          rvalid_o,
    output logic                          err_o,
    output logic                          zeroize_busy_o,
    output logic                          sram_cs_o,
    output logic                          sram_we_o,
    output logic [AW-1:0]                 sram_addr_o,
    output logic [ABR_MEM_DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [ABR_MEM_DATA_WIDTH-1:0] sram_rdata_i
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    logic [2:0]           bank_s;
    logic [10:0]          row_s;
    logic [1:0]           mode_s;
    logic                 is_rd_s;
    logic                 is_wr_s;
    logic                 is_bad_s;
    logic                 bank_hit_s;
    logic                 row_ok_s;
    logic                 block_s;
    logic                 access_s;
    logic                 err_s;
    logic                 sweep_busy_s;
    logic [AW-1:0]        sweep_row_s;
    logic [SRAM_RD_LAT:0] vld_pipe_r;

`ifdef ABR_MEM_RESPONDER_ZEROIZE_EN
    abr_mem_zeroize_sweep #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sweep (
        .clk     (clk),
        .rst     (rst),
        .zeroize (zeroize),
        .busy_o  (sweep_busy_s),
        .row_o   (sweep_row_s)
    );

    // A zeroize pulse wins over a request arriving in the same cycle.
    assign block_s        = sweep_busy_s | zeroize;
    assign zeroize_busy_o = sweep_busy_s;
`else
    logic zeroize_unused_s;

    assign zeroize_unused_s = zeroize;
    assign sweep_busy_s     = 1'b0;
    assign sweep_row_s      = '0;
    assign block_s          = 1'b0;
    assign zeroize_busy_o   = 1'b0;
`endif

    // Request decode: bank/row split, mode classification, accept/error.
    always_comb begin
        bank_s   = mem_req_i.addr[13:11];
        row_s    = mem_req_i.addr[10:0];
        mode_s   = mem_req_i.rd_wr_en;
        is_rd_s  = 1'b0;
        is_wr_s  = 1'b0;
        is_bad_s = 1'b0;
        case (mode_s)
            RW_READ:  is_rd_s  = 1'b1;
            RW_WRITE: is_wr_s  = 1'b1;
            2'b11:    is_bad_s = 1'b1;
            default:  is_bad_s = 1'b0;
        endcase
        bank_hit_s = (bank_s == 3'(BANK_ID));
        row_ok_s   = ({21'd0, row_s} < DEPTH_U);
        access_s   = bank_hit_s & (is_rd_s | is_wr_s) & row_ok_s & ~block_s;
        err_s      = bank_hit_s & (is_bad_s | ((is_rd_s | is_wr_s) & (~row_ok_s | block_s)));
    end

    // Registered SRAM port, error pulse and read-valid delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_cs_o    <= 1'b0;
            sram_we_o    <= 1'b0;
            sram_addr_o  <= '0;
            sram_wdata_o <= '0;
            err_o        <= 1'b0;
            vld_pipe_r   <= '0;
            rvalid_o     <= 1'b0;
            rdata_o      <= '0;
        end else begin
            err_o      <= err_s;
            vld_pipe_r <= {vld_pipe_r[SRAM_RD_LAT-1:0], access_s & is_rd_s};
            rvalid_o   <= vld_pipe_r[SRAM_RD_LAT];
            rdata_o    <= vld_pipe_r[SRAM_RD_LAT] ? sram_rdata_i : '0;
            if (sweep_busy_s) begin
                sram_cs_o    <= 1'b1;
                sram_we_o    <= 1'b1;
                sram_addr_o  <= sweep_row_s;
                sram_wdata_o <= '0;
            end else if (access_s) begin
                sram_cs_o    <= 1'b1;
                sram_we_o    <= is_wr_s;
                sram_addr_o  <= AW'(row_s);
                sram_wdata_o <= is_wr_s ? wdata_i : '0;
            end else begin
                sram_cs_o    <= 1'b0;
                sram_we_o    <= 1'b0;
                sram_addr_o  <= '0;
                sram_wdata_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_abr_mem_responder.sv
// Scoreboard bench for abr_mem_responder: a default instance and an
// SRAM_RD_LAT=2 instance share stimulus, each backed by a behavioural SRAM.
module tb_abr_mem_responder;
    import abr_params_pkg::*;

    localparam int DEPTH = 832;
    localparam int AW    = 10;
    localparam int DW    = 96;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          zeroize = 1'b0;
    mem_if_t       req;
    logic [DW-1:0] wdata;

    logic [DW-1:0] rdata1, wd1, srd1, rdata2, wd2, srd2;
    logic          rvalid1, err1, busy1, cs1, we1;
    logic          rvalid2, err2, busy2, cs2, we2;
    logic [AW-1:0] addr1, addr2;

    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem2 [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] rda1, rda2, rdb2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    abr_mem_responder u_dut1 (
        .clk(clk), .rst(rst), .zeroize(zeroize), .mem_req_i(req), .wdata_i(wdata),
        .rdata_o(rdata1), .rvalid_o(rvalid1), .err_o(err1), .zeroize_busy_o(busy1),
        .sram_cs_o(cs1), .sram_we_o(we1), .sram_addr_o(addr1), .sram_wdata_o(wd1),
        .sram_rdata_i(srd1)
    );

    abr_mem_responder #(.SRAM_RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .zeroize(zeroize), .mem_req_i(req), .wdata_i(wdata),
        .rdata_o(rdata2), .rvalid_o(rvalid2), .err_o(err2), .zeroize_busy_o(busy2),
        .sram_cs_o(cs2), .sram_we_o(we2), .sram_addr_o(addr2), .sram_wdata_o(wd2),
        .sram_rdata_i(srd2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cs1 && !we1) rda1 <= mem1[addr1];
        if (cs1 && we1) mem1[addr1] <= wd1;
    end

    always @(posedge clk) begin
        if (cs2 && !we2) rda2 <= mem2[addr2];
        rdb2 <= rda2;
        if (cs2 && we2) mem2[addr2] <= wd2;
    end

    assign srd1 = rda1;
    assign srd2 = rdb2;

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (rvalid1) begin
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid1_unexpected cycle %0d got 1 want 0", cyc);
                end else begin
                    e1 = q1.pop_front();
                    if (rdata1 !== e1.data || cyc !== e1.cyc)
                        begin errors++; $display("FAIL rd1 got %h @%0d want %h @%0d", rdata1, cyc, e1.data, e1.cyc); end
                end
            end else if (rdata1 !== '0) begin
                errors++;
                $display("FAIL rdata1_idle got %h want 0", rdata1);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (rvalid2) begin
                if (q2.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid2_unexpected cycle %0d got 1 want 0", cyc);
                end else begin
                    e2 = q2.pop_front();
                    if (rdata2 !== e2.data || cyc !== e2.cyc)
                        begin errors++; $display("FAIL rd2 got %h @%0d want %h @%0d", rdata2, cyc, e2.data, e2.cyc); end
                end
            end else if (rdata2 !== '0) begin
                errors++;
                $display("FAIL rdata2_idle got %h want 0", rdata2);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Drive one request for a cycle; returns in the cycle after acceptance (T+1).
    task automatic send(input logic [1:0] m, input logic [13:0] a, input logic [DW-1:0] d, input bit ok);
        exp_t e;
        req.rd_wr_en = mem_rw_mode_e'(m);
        req.addr     = a;
        wdata        = d;
        if (ok && m == 2'b01) begin
            e.data = ref_mem[a[9:0]];
            e.cyc  = cyc + 3;
            q1.push_back(e);
            e.cyc  = cyc + 4;
            q2.push_back(e);
        end
        if (ok && m == 2'b10) ref_mem[a[9:0]] = d;
        @(negedge clk);
    endtask

    task automatic idle();
        req.rd_wr_en = RW_IDLE;
        req.addr     = 14'd0;
        wdata        = '0;
    endtask

    task automatic drain();
        for (int k = 0; k < 12; k++) begin
            if (q1.size() == 0 && q2.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d/%0d want 0/0", q1.size(), q2.size());
        end
        q1.delete();
        q2.delete();
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({rdata1, rvalid1, err1, busy1, cs1, we1, addr1, wd1} !== '0) begin
            errors++;
            $display("FAIL %s dut1 got rv=%b err=%b busy=%b cs=%b we=%b addr=%0d want all 0",
                     tag, rvalid1, err1, busy1, cs1, we1, addr1);
        end
        checks++;
        if ({rdata2, rvalid2, err2, busy2, cs2, we2, addr2, wd2} !== '0) begin
            errors++;
            $display("FAIL %s dut2 got rv=%b err=%b busy=%b cs=%b we=%b addr=%0d want all 0",
                     tag, rvalid2, err2, busy2, cs2, we2, addr2);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_write_read();
        send(2'b10, 14'h0005, {12{8'hA5}}, 1'b1);
        checks++;
        if ({cs1, we1, addr1, err1} !== {1'b1, 1'b1, 10'd5, 1'b0} || wd1 !== {12{8'hA5}}) begin
            errors++;
            $display("FAIL write_strobe got cs=%b we=%b addr=%0d err=%b want 1 1 5 0", cs1, we1, addr1, err1);
        end
        send(2'b01, 14'h0005, '0, 1'b1);
        checks++;
        if ({cs1, we1, addr1, cs2, addr2} !== {1'b1, 1'b0, 10'd5, 1'b1, 10'd5}) begin
            errors++;
            $display("FAIL read_strobe got cs=%b we=%b addr=%0d want 1 0 5", cs1, we1, addr1);
        end
        idle();
        @(negedge clk);
        checks++;
        if (cs1 !== 1'b0 || we1 !== 1'b0) begin
            errors++;
            $display("FAIL strobe_single got cs=%b we=%b want 0 0", cs1, we1);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) send(2'b10, 14'(r), {3{32'hBEEF_0000 + 32'(r)}}, 1'b1);
        for (int r = 0; r < 3; r++) begin
            send(2'b01, 14'(r), '0, 1'b1);
            checks++;
            if (cs1 !== 1'b1 || addr1 !== AW'(r)) begin
                errors++;
                $display("FAIL b2b_strobe%0d got cs=%b addr=%0d want 1 %0d", r, cs1, addr1, r);
            end
        end
        send(2'b01, 14'd831, '0, 1'b1);
        send(2'b01, 14'd400, '0, 1'b1);
        idle();
        drain();
    endtask

    task automatic test_out_of_range();
        send(2'b01, 14'h0340, '0, 1'b0);
        checks++;
        if (err1 !== 1'b1 || cs1 !== 1'b0) begin
            errors++;
            $display("FAIL oor_read got err=%b cs=%b want 1 0", err1, cs1);
        end
        idle();
        @(negedge clk);
        checks++;
        if (err1 !== 1'b0) begin
            errors++;
            $display("FAIL err_single got %b want 0", err1);
        end
        send(2'b10, 14'h07FF, {12{8'h3C}}, 1'b0);
        checks++;
        if (err1 !== 1'b1 || cs1 !== 1'b0) begin
            errors++;
            $display("FAIL oor_write got err=%b cs=%b want 1 0", err1, cs1);
        end
        send(2'b11, 14'h0005, '0, 1'b0);
        checks++;
        if (err1 !== 1'b1 || cs1 !== 1'b0) begin
            errors++;
            $display("FAIL illegal_mode got err=%b cs=%b want 1 0", err1, cs1);
        end
        idle();
        repeat (5) @(negedge clk);
        drain();
    endtask

    task automatic test_other_bank();
        send(2'b01, 14'h0805, '0, 1'b0);
        checks++;
        if (err1 !== 1'b0 || cs1 !== 1'b0) begin
            errors++;
            $display("FAIL other_bank got err=%b cs=%b want 0 0", err1, cs1);
        end
        send(2'b11, 14'h0805, '0, 1'b0);
        checks++;
        if (err1 !== 1'b0 || cs1 !== 1'b0) begin
            errors++;
            $display("FAIL other_bank_bad got err=%b cs=%b want 0 0", err1, cs1);
        end
        send(2'b00, 14'h0005, '0, 1'b0);
        checks++;
        if (err1 !== 1'b0 || cs1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_mode got err=%b cs=%b want 0 0", err1, cs1);
        end
        idle();
        repeat (5) @(negedge clk);
        drain();
    endtask

    task automatic test_inflight_reset();
        send(2'b01, 14'h0003, '0, 1'b0);
        idle();
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("inflight_rst");
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (rvalid1 !== 1'b0 || rvalid2 !== 1'b0) begin
                errors++;
                $display("FAIL rst_discard got %b/%b want 0/0", rvalid1, rvalid2);
            end
        end
    endtask

`ifdef ABR_MEM_RESPONDER_ZEROIZE_EN
    task automatic test_zeroize();
        int busy_n = 0;
        int wr_n   = 0;
        int bad    = 0;
        int row    = 0;
        send(2'b01, 14'h0005, '0, 1'b1);
        zeroize = 1'b1;
        send(2'b01, 14'h0006, '0, 1'b0);
        zeroize = 1'b0;
        idle();
        checks++;
        if (err1 !== 1'b1 || cs1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL zeroize_start got err=%b cs=%b busy=%b want 1 0 1", err1, cs1, busy1);
        end
        for (int k = 0; k < 2000; k++) begin
            if (busy1) busy_n++;
            if (cs1) begin
                if (we1 !== 1'b1 || wd1 !== '0 || addr1 !== AW'(row)) bad++;
                row++;
                wr_n++;
            end
            if (k == 10) begin req.rd_wr_en = RW_READ; req.addr = 14'h0005; end
            if (k == 11) begin
                idle();
                checks++;
                if (err1 !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep_req_err got %b want 1", err1);
                end
            end
            if (k == 20) zeroize = 1'b1;
            if (k == 21) zeroize = 1'b0;
            if (k > 0 && !busy1 && !cs1) break;
            @(negedge clk);
        end
        checks++;
        if (busy_n != DEPTH || wr_n != DEPTH || bad != 0) begin
            errors++;
            $display("FAIL sweep got busy=%0d writes=%0d bad=%0d want %0d %0d 0", busy_n, wr_n, bad, DEPTH, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        send(2'b01, 14'h0005, '0, 1'b1);
        idle();
        drain();
    endtask

    task automatic test_reset_mid_sweep();
        bit found = 1'b0;
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (cs1 && addr1 == 10'd100) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL sweep_row100 got 0 want 1");
        end
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_sweep_rst");
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || cs1 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_idle got busy=%b cs=%b want 0 0", busy1, cs1);
        end
        send(2'b01, 14'd0, '0, 1'b1);
        send(2'b01, 14'd200, '0, 1'b1);
        idle();
        drain();
    endtask
`else
    task automatic test_zeroize_disabled();
        zeroize = 1'b1;
        send(2'b01, 14'h0005, '0, 1'b1);
        zeroize = 1'b0;
        idle();
        checks++;
        if (err1 !== 1'b0 || cs1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL zeroize_off got err=%b cs=%b busy=%b want 0 1 0", err1, cs1, busy1);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (busy1 !== 1'b0 || busy2 !== 1'b0 || cs1 !== 1'b0) begin
                errors++;
                $display("FAIL zeroize_off_idle got busy=%b cs=%b want 0 0", busy1, cs1);
            end
        end
        drain();
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = {3{32'(i) ^ 32'hC0DE_0000}};
            mem1[i]    = ref_mem[i];
            mem2[i]    = ref_mem[i];
        end
        rda1 = '0;
        rda2 = '0;
        rdb2 = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_other_bank();
        test_inflight_reset();
`ifdef ABR_MEM_RESPONDER_ZEROIZE_EN
        test_zeroize();
        test_reset_mid_sweep();
`else
        test_zeroize_disabled();
`endif
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/abr_mem_responder.md
ABR_MEM_RESPONDER -- requirements
Module: abr_mem_responder

Interface
REQ-001 SHALL have parameter BANK_ID, default 0, meaning the 3-bit bank index this responder serves.
REQ-002 SHALL have parameter DEPTH, default ABR_MEM_INST0_DEPTH (832), meaning the number of valid rows.
REQ-003 SHALL have parameter SRAM_RD_LAT, default 1, meaning the SRAM strobe-to-rdata latency in cycles; legal values are 1 and 2.
REQ-004 SHALL have port: clk  input  1  sole clock.
REQ-005 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port: zeroize  input  1  pulse requesting a memory wipe.
REQ-007 SHALL have port: mem_req_i  input  mem_if_t  request carrying rd_wr_en and a 14-bit addr.
REQ-008 SHALL have port: wdata_i  input  96  write data, valid with RW_WRITE.
REQ-009 SHALL have port: rdata_o  output  96  read data.
REQ-010 SHALL have port: rvalid_o  output  1  read data valid.
REQ-011 SHALL have port: err_o  output  1  one-cycle error pulse.
REQ-012 SHALL have port: zeroize_busy_o  output  1  wipe in progress.
REQ-013 SHALL have ports: sram_cs_o  output  1; sram_we_o  output  1; sram_addr_o  output  $clog2(DEPTH); sram_wdata_o  output  96; sram_rdata_i  input  96.

Function
REQ-014 Address decode SHALL be: bank = addr[13:11], row = addr[10:0].
REQ-015 A request SHALL be selected when rd_wr_en is RW_READ or RW_WRITE and bank equals BANK_ID; otherwise it SHALL be ignored with no outputs changed.
REQ-016 A selected request with row < DEPTH, accepted at cycle T, SHALL drive registered sram_cs_o=1, sram_addr_o=row, sram_we_o=(RW_WRITE), and sram_wdata_o=wdata_i at T+1.
REQ-017 For a read accepted at T, rvalid_o SHALL be 1 at T+2+SRAM_RD_LAT, with rdata_o holding a registered copy of sram_rdata_i.
REQ-018 rdata_o SHALL be 0 whenever rvalid_o is 0.
REQ-019 The block SHALL be fully pipelined: one request per cycle, with responses in request order.
REQ-020 Writes SHALL produce no rvalid_o.
REQ-021 A selected request with row >= DEPTH SHALL pulse err_o at T+1, assert no sram_cs_o, and produce no rvalid_o.
REQ-022 rd_wr_en=2'b11 with matching bank SHALL pulse err_o at T+1 and perform no access.
REQ-023 sram_cs_o, sram_we_o and err_o SHALL be single-cycle per request.
REQ-024 Zeroize FSM states SHALL be IDLE and SWEEP.
REQ-025 The FSM SHALL move IDLE->SWEEP on zeroize, and SWEEP->IDLE after writing row DEPTH-1.
REQ-026 In SWEEP, the block SHALL issue one write per cycle with sram_we_o=1, sram_wdata_o=0, and rows ascending from 0; zeroize_busy_o=1 throughout.
REQ-027 A selected request arriving during SWEEP SHALL be dropped and SHALL pulse err_o at T+1.
REQ-028 zeroize asserted during SWEEP SHALL be ignored; the sweep SHALL not restart.
REQ-029 Reads already in flight when SWEEP starts SHALL complete normally.
REQ-030 zeroize and a selected request arriving in the same IDLE cycle: the request SHALL be dropped with err_o, and the sweep SHALL start.

Reset
REQ-031 On rst, the following outputs SHALL be 0: rdata_o, rvalid_o, err_o, zeroize_busy_o, sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o.
REQ-032 On rst, the FSM SHALL go to IDLE, the sweep counter SHALL clear, and in-flight reads SHALL be discarded without any rvalid_o.
REQ-033 After rst mid-SWEEP, memory contents are unspecified; the FSM SHALL be IDLE on the first cycle after rst deasserts.

Configuration
REQ-034 The macro ABR_MEM_RESPONDER_ZEROIZE_EN SHALL control the zeroize feature.
REQ-035 With ABR_MEM_RESPONDER_ZEROIZE_EN defined, the zeroize FSM and sweep counter SHALL be present as specified above.
REQ-036 Without ABR_MEM_RESPONDER_ZEROIZE_EN, zeroize SHALL be ignored, zeroize_busy_o SHALL be tied 0, and no sweep logic SHALL exist; all other behaviour SHALL be unchanged.

Structure
REQ-037 mem_if_t, mem_rw_mode_e, ABR_MEM_ADDR_WIDTH, ABR_MEM_DATA_WIDTH and ABR_MEM_INST*_DEPTH SHALL come from abr_params_pkg; no new package types.
REQ-038 The read-valid delay line SHALL be a local shift register of length 1+SRAM_RD_LAT.
REQ-039 The sweep FSM and row counter SHALL be the sub-module abr_mem_zeroize_sweep, instantiated only under the macro.

Verification
REQ-040 Defaults: write row 5 with 96'hA5A5..A5, then read addr 14'h0005 at T -> sram_cs_o/addr=5 at T+1, rvalid_o=1 and rdata_o=A5A5..A5 at T+3.
REQ-041 Back-to-back reads of rows 0,1,2 at T, T+1, T+2 -> rvalid_o high at T+3..T+5 with data in order.
REQ-042 Read addr 14'h0340 (row 832) -> err_o pulse at T+1, no sram_cs_o, no rvalid_o.
REQ-043 Request to addr 14'h0805 (bank 1) with BANK_ID=0 -> no sram_cs_o, no err_o, no rvalid_o.
REQ-044 zeroize pulse -> zeroize_busy_o high 832 cycles, writes of 0 to rows 0..831; a read during the sweep -> err_o; a read of row 5 after the sweep -> rdata_o=0.
REQ-045 rst asserted at sweep row 100 -> next cycle zeroize_busy_o=0 and all outputs 0; SRAM_RD_LAT=2 read -> rvalid_o at T+4.
